// File: rtl/asin_taylor.sv
// asin_taylor: y = (2/pi)*asin(s) via a sequential 5-term odd Taylor multiply-accumulate.
// Optional build macro ASIN_TAYLOR_ROUND_EN: round-half-up on every arithmetic shift instead of floor.
module asin_taylor #(
    parameter int G_DWIDTH   = 16,
    parameter int G_TAPWIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                bypass,
    input  logic [G_DWIDTH-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [G_DWIDTH-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);
    localparam int DW  = G_DWIDTH;
    localparam int TW  = G_TAPWIDTH;
    localparam int XW  = DW + 1;    // p and sq need one extra bit: (-1)^2 = +1
    localparam int PW  = 2 * XW;
    localparam int TRW = DW + TW;
    localparam int AW  = DW + TW + 3;

`ifdef ASIN_TAYLOR_ROUND_EN
    localparam logic RND_EN = 1'b1;
`else
    localparam logic RND_EN = 1'b0;
`endif
    localparam logic signed [PW-1:0] RND_P = PW'(RND_EN) <<< (DW - 2);
    localparam logic signed [AW-1:0] RND_A = AW'(RND_EN) <<< (TW - 2);
    localparam logic signed [AW-1:0] DMAX  = (AW'(1) <<< (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] DMIN  = -DMAX - AW'(1);

    localparam logic [2:0] SM_IDLE   = 3'd0;
    localparam logic [2:0] SM_SQUARE = 3'd1;
    localparam logic [2:0] SM_TERM   = 3'd2;
    localparam logic [2:0] SM_ACCUM  = 3'd3;
    localparam logic [2:0] SM_OUTPUT = 3'd4;

    function automatic int coef_int(input int k);
        real c;
        case (k)
            0:       c = 0.6366197724;
            1:       c = 0.1061032954;
            2:       c = 0.0477464829;
            3:       c = 0.0284205256;
            4:       c = 0.0193417551;
            default: c = 0.0;
        endcase
        return $rtoi(c * (2.0 ** (TW - 1)) + 0.5);
    endfunction

    logic signed [TW-1:0] coef [0:7];
    for (genvar gi = 0; gi < 8; gi++) begin : g_coef
        localparam int CI = coef_int(gi);
        assign coef[gi] = CI[TW-1:0];
    end

    logic [2:0]            state_q, state_d;
    logic signed [XW-1:0]  p_q, p_d;
    logic signed [XW-1:0]  sq_q, sq_d;
    logic signed [TRW-1:0] term_q, term_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [2:0]            k_q, k_d;
    logic [DW-1:0]         dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  din_ready_q, din_ready_d;

    // One shared multiplier: p*p while squaring (p still holds s), p*sq while accumulating.
    logic signed [XW-1:0]  mul_b;
    logic signed [PW-1:0]  mul_prod;
    logic signed [XW-1:0]  mul_sh;
    logic signed [TRW-1:0] term_prod;
    logic signed [AW-1:0]  acc_sum;
    logic signed [AW-1:0]  acc_sh;
    logic [DW-1:0]         dout_sat;

    assign mul_b     = (state_q == SM_SQUARE) ? p_q : sq_q;
    assign mul_prod  = PW'(p_q) * PW'(mul_b);
    assign mul_sh    = XW'((mul_prod + RND_P) >>> (DW - 1));
    assign term_prod = TRW'(p_q) * TRW'(coef[k_q]);
    assign acc_sum   = acc_q + AW'(term_q);
    assign acc_sh    = (acc_sum + RND_A) >>> (TW - 1);

    always_comb begin
        dout_sat = DW'(acc_sh);
        if (acc_sh > DMAX) begin
            dout_sat = DW'(DMAX);
        end else if (acc_sh < DMIN) begin
            dout_sat = DW'(DMIN);
        end
    end

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        sq_d         = sq_q;
        term_d       = term_q;
        acc_d        = acc_q;
        k_d          = k_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        din_ready_d  = din_ready_q;
        case (state_q)
            SM_IDLE: begin
                if (!din_ready_q) begin
                    din_ready_d = 1'b1;
                end else if (din_valid) begin
                    din_ready_d = 1'b0;
                    p_d         = XW'($signed(din));
                    acc_d       = '0;
                    k_d         = '0;
                    if (bypass) begin
                        dout_d  = din;
                        state_d = SM_OUTPUT;
                    end else begin
                        state_d = SM_SQUARE;
                    end
                end
            end
            SM_SQUARE: begin
                sq_d    = mul_sh;
                state_d = SM_TERM;
            end
            SM_TERM: begin
                term_d  = term_prod;
                state_d = SM_ACCUM;
            end
            SM_ACCUM: begin
                acc_d = acc_sum;
                p_d   = mul_sh;
                if (k_q == 3'd4) begin
                    dout_d       = dout_sat;
                    dout_valid_d = 1'b1;
                    state_d      = SM_OUTPUT;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = SM_TERM;
                end
            end
            SM_OUTPUT: begin
                // Bypass arrives here with valid still low; it rises on the next edge.
                if (dout_valid_q && dout_ready) begin
                    dout_valid_d = 1'b0;
                    din_ready_d  = 1'b1;
                    state_d      = SM_IDLE;
                end else begin
                    dout_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = SM_IDLE;
            end
        endcase
        if (!enable) begin
            state_d      = SM_IDLE;
            p_d          = '0;
            sq_d         = '0;
            term_d       = '0;
            acc_d        = '0;
            k_d          = '0;
            dout_d       = '0;
            dout_valid_d = 1'b0;
            din_ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SM_IDLE;
            p_q          <= '0;
            sq_q         <= '0;
            term_q       <= '0;
            acc_q        <= '0;
            k_q          <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            sq_q         <= sq_d;
            term_q       <= term_d;
            acc_q        <= acc_d;
            k_q          <= k_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            din_ready_q  <= din_ready_d;
        end
    end

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
